bus_arbiter3: RTL

- Round-robin arbiter that shares one 8-bit datapath resource (shared bus or memory port) among three requesters.
- Drives the 2-bit select of the 3:1 8-bit datapath mux (0 selects in1, 1 selects in2, 2 selects in3) and a one-hot grant back to the requesters.
- Bounds how long a grantee holds the resource while others wait, so no requester starves.

---
 rtl/bus_arbiter3_if.sv | 22 ++
 rtl/bus_arbiter3.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter3_if.sv
// Request/grant bundle between three requesters and the shared-datapath arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface bus_arbiter3_if;
  logic [2:0] req;    // one bit per requester, held for the whole transaction
  logic [2:0] grant;  // one-hot owner, or zero when idle
  logic [1:0] sel;    // 3:1 datapath mux select (0..2)
  logic       busy;   // resource currently owned

  modport master (
    output req,
    input  grant,
    input  sel,
    input  busy
  );

  modport slave (
    input  req,
    output grant,
    output sel,
    output busy
  );
endinterface

// File: rtl/bus_arbiter3.sv
// Three-way round-robin arbiter for a shared 8-bit datapath.
// A grantee may hold the resource for at most MAX_BURST consecutive cycles
// while someone else is waiting; an uncontested grantee keeps it indefinitely.
// All outputs come straight from flops, one cycle after the request is sampled.
// MAX_BURST must be 1..7 and CNT_W wide enough to hold MAX_BURST-1.
module bus_arbiter3 #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter3_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  // (base + off) mod 3 for a base already in 0..2.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input int unsigned off);
    int unsigned s;
    s = int'(base) + off;
    return 2'(s % 3);
  endfunction

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       last_reg, last_next;
  logic [1:0]       sel_reg, sel_next;
  logic [2:0]       grant_reg, grant_next;
  logic             busy_reg, busy_next;

  // Round-robin candidates in priority order: last+1, last+2, last.
  logic [1:0] cand [3];
  logic [2:0] cand_req;
  logic       win_valid;
  logic [1:0] win_idx;

  // Ownership view of the current grantee (last_reg is the owner while in OWN).
  logic [2:0] owner_onehot;
  logic       own_req;
  logic       others_pending;
  logic       take_grant;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    assign cand[gi]     = rr_add(last_reg, gi + 1);
    assign cand_req[gi] = bus.req[cand[gi]];
    assign owner_onehot[gi] = (last_reg == 2'(gi));
  end

  assign own_req        = |(bus.req & owner_onehot);
  assign others_pending = |(bus.req & ~owner_onehot);

  // Pick the first requesting candidate in rotation order.
  always_comb begin
    win_valid = |cand_req;
    win_idx   = cand[2];
    if (cand_req[0]) begin
      win_idx = cand[0];
    end else if (cand_req[1]) begin
      win_idx = cand[1];
    end
  end

  // State, burst counter and rotation pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 2'd2;
      sel_reg   <= 2'd0;
      grant_reg <= 3'b000;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state decision: new grant, hold with burst counting, or release to idle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    take_grant = 1'b0;

    case (state_reg)
      IDLE: begin
        // sel keeps its old value while idle so the mux output stays stable.
        if (win_valid) begin
          take_grant = 1'b1;
        end
      end
      OWN: begin
        if (!own_req) begin
          // Hand over with no idle bubble if someone else is waiting.
          if (others_pending) begin
            take_grant = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if ((cnt_reg == CNT_MAX) && others_pending) begin
          // Burst limit hit under contention; the winner can never be the
          // current owner because it is checked last in the rotation.
          take_grant = 1'b1;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (take_grant) begin
      state_next = OWN;
      last_next  = win_idx;
      sel_next   = win_idx;
      cnt_next   = '0;
    end
  end

  // Registered-output decode: grant follows the next owner, busy mirrors OWN.
  always_comb begin
    grant_next = 3'b000;
    busy_next  = 1'b0;
    if (state_next == OWN) begin
      busy_next = 1'b1;
      for (int i = 0; i < 3; i++) begin
        grant_next[i] = (last_next == 2'(i));
      end
    end
  end

  assign bus.grant = grant_reg;
  assign bus.sel   = sel_reg;
  assign bus.busy  = busy_reg;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.grant));
  a_sel_legal:     assert property (@(posedge clk) disable iff (rst) bus.sel != 2'd3);
  a_busy_match:    assert property (@(posedge clk) disable iff (rst) bus.busy == (|bus.grant));
  a_sel_owner:     assert property (@(posedge clk) disable iff (rst) bus.busy |-> bus.grant[bus.sel]);
`endif

endmodule
